sum_of_squares: RTL

- Streaming front end that feeds the pipelined square-root block.
- Takes signed vector components one per cycle and squares each one.
- Accumulates the squares per vector and emits one 32-bit sum-of-squares per vector, framed by a last marker.
- The output pair sum_out/sum_valid connects directly to the square root's data_in/data_valid. Downstream has no backpressure, so the output is a fire-and-forget one-cycle pulse.

---
 rtl/sos_pkg.sv | 23 ++
 rtl/sos_square.sv | 76 +++++++
 rtl/sum_of_squares.sv | 115 +++++++++++
 3 files changed

// File: rtl/sos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sos_pkg
//  Description : Shared widths, saturation constant and data typedefs for the
//                sum-of-squares front end feeding the square-root block.
//  Revision    : 1.0 - initial release
// ============================================================================
package sos_pkg;

    // Default widths; instances may override these through parameters
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_LEN_W  = 8;

    // All-ones value the accumulator clamps to on overflow
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

    typedef logic signed [DEF_DATA_W-1:0]   sample_t;
    typedef logic        [2*DEF_DATA_W-1:0] square_t;
    typedef logic        [DEF_ACC_W-1:0]    acc_t;

endpackage : sos_pkg
`default_nettype wire

// File: rtl/sos_square.sv
`default_nettype none
// ============================================================================
//  Module      : sos_square
//  Description : Two-stage registered signed squarer. Stage 1 captures the
//                sample, stage 2 holds its unsigned square. Valid and last
//                travel alongside the data; clear flushes both stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module sos_square import sos_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     sample_last,
    output logic [2*DATA_W-1:0]      sq_out,
    output logic                     sq_valid,
    output logic                     sq_last
);

    logic signed [DATA_W-1:0]   r_s1_data;
    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic [2*DATA_W-1:0]        r_s2_sq;
    logic                       r_s2_valid;
    logic                       r_s2_last;

    // Full-width signed product; a square is never negative, so the bit
    // pattern is also the unsigned magnitude (including (-2^(N-1))^2).
    logic signed [2*DATA_W-1:0] w_prod;
    assign w_prod = r_s1_data * r_s1_data;

    // Stage 1: capture the incoming component; last only counts when valid
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= sample_valid;
            r_s1_last  <= sample_valid & sample_last;
            if (sample_valid) begin
                r_s1_data <= sample_in;
            end
        end
    end

    // Stage 2: register the square of the stage-1 sample
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_sq    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (clear) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            if (r_s1_valid) begin
                r_s2_sq <= w_prod;
            end
        end
    end

    assign sq_out   = r_s2_sq;
    assign sq_valid = r_s2_valid;
    assign sq_last  = r_s2_last;

endmodule : sos_square
`default_nettype wire

// File: rtl/sum_of_squares.sv
`default_nettype none
// ============================================================================
//  Module      : sum_of_squares
//  Description : Streaming sum-of-squares accumulator. Squares one signed
//                component per cycle, accumulates per vector with sticky
//                saturation, and emits a one-cycle result pulse on last.
//                Output pairs directly with the square-root block input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_of_squares import sos_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,   // must be >= 2*DATA_W
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     sample_last,
    output logic [ACC_W-1:0]         sum_out,
    output logic                     sum_valid,
    output logic                     sum_sat,
    output logic [LEN_W-1:0]         vec_len
);

    localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};
    localparam logic [LEN_W-1:0] c_len_max = {LEN_W{1'b1}};
    localparam int               c_pad_w   = ACC_W + 1 - 2*DATA_W;

    logic [2*DATA_W-1:0] w_sq;
    logic                w_sq_valid;
    logic                w_sq_last;

    sos_square #(
        .DATA_W (DATA_W)
    ) u_square (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_last  (sample_last),
        .sq_out       (w_sq),
        .sq_valid     (w_sq_valid),
        .sq_last      (w_sq_last)
    );

    // Running state of the vector being accumulated; count != 0 means
    // a vector is in progress.
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_count;
    logic             r_sticky;

    logic [ACC_W-1:0] r_sum_out;
    logic             r_sum_valid;
    logic             r_sum_sat;
    logic [LEN_W-1:0] r_vec_len;

    // One extra bit on the adder catches the carry-out used as overflow
    logic [ACC_W:0]   w_sq_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_sat;
    logic [ACC_W-1:0] w_acc_next;
    logic [LEN_W-1:0] w_count_next;

    assign w_sq_ext     = {{c_pad_w{1'b0}}, w_sq};
    assign w_sum        = {1'b0, r_acc} + w_sq_ext;
    assign w_sat        = w_sum[ACC_W] | r_sticky;
    assign w_acc_next   = w_sat ? c_acc_max : w_sum[ACC_W-1:0];
    assign w_count_next = (r_count == c_len_max) ? r_count : r_count + 1'b1;

    // Stage 3: accumulate squares, publish the result and restart on last
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_sticky    <= 1'b0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
            r_sum_sat   <= 1'b0;
            r_vec_len   <= '0;
        end else if (clear) begin
            // Result registers keep the last published vector
            r_acc       <= '0;
            r_count     <= '0;
            r_sticky    <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_sq_valid) begin
                if (w_sq_last) begin
                    r_sum_out   <= w_acc_next;
                    r_sum_sat   <= w_sat;
                    r_vec_len   <= w_count_next;
                    r_sum_valid <= 1'b1;
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc       <= w_acc_next;
                    r_count     <= w_count_next;
                    r_sticky    <= w_sat;
                end
            end
        end
    end

    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign sum_sat   = r_sum_sat;
    assign vec_len   = r_vec_len;

endmodule : sum_of_squares
`default_nettype wire
